// File: rtl/bmf_pkg.sv
// Shared types and helpers for the BMF basis-matrix decoder.
package bmf_pkg;

  localparam int unsigned CNT_W = 32;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Index width that never collapses to zero bits (K = 1 still needs a 1-bit row port).
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Callers zero-extend their M-bit word (M <= 64) to the 64-bit argument.
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < 64; i++) cnt = cnt + 7'(v[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/bmf_h_rowmux.sv
// Combinational K x M select-and-accumulate: o_po = OR/XOR of rows i where i_k[i] is set.
module bmf_h_rowmux #(
  parameter int unsigned K        = 4,
  parameter int unsigned M        = 5,
  parameter int unsigned XOR_MODE = 0
) (
  input  logic [K-1:0]   i_k,
  input  logic [K*M-1:0] i_h,
  output logic [M-1:0]   o_po
);

  logic [M-1:0] w_acc;

  always_comb begin
    w_acc = '0;
    for (int i = 0; i < K; i++) begin
      if (i_k[i]) begin
        w_acc = (XOR_MODE != 0) ? (w_acc ^ i_h[i*M +: M]) : (w_acc | i_h[i*M +: M]);
      end
    end
  end

  assign o_po = w_acc;

endmodule

// File: rtl/bmf_h_decoder.sv
// Streaming BMF decompressor: run-time loaded K x M basis H, po = k (x) H, 1-cycle latency.
// Optional error monitor (ref_po, err_bits, err_words, tot_words) under BMF_H_DECODER_ERR_MON_EN.
module bmf_h_decoder
  import bmf_pkg::*;
#(
  parameter int unsigned K        = 4,
  parameter int unsigned M        = 5,
  parameter int unsigned XOR_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [clog2_min1(K)-1:0]   ld_row,
  input  logic [M-1:0]               ld_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [K-1:0]               in_k,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [M-1:0]               out_po,
  output logic                       basis_ok
`ifdef BMF_H_DECODER_ERR_MON_EN
  ,
  input  logic [M-1:0]               ref_po,
  output logic [CNT_W-1:0]           err_bits,
  output logic [CNT_W-1:0]           err_words,
  output logic [CNT_W-1:0]           tot_words
`endif
);

  localparam int unsigned RW = clog2_min1(K);

  state_e         r_state, w_state_nxt;
  logic [K-1:0]   r_mask, w_mask_nxt;
  logic [K-1:0]   w_row_sel;
  logic [K*M-1:0] r_h;
  logic           r_out_valid;
  logic [M-1:0]   r_out_po;
  logic [M-1:0]   w_po;
  logic           w_ld_fire, w_in_fire, w_out_fire;

  assign ld_ready   = (r_state == LOAD);
  assign in_ready   = (r_state == RUN) && (!r_out_valid || out_ready);
  assign basis_ok   = (r_state == RUN);
  assign out_valid  = r_out_valid;
  assign out_po     = r_out_po;
  assign w_out_fire = r_out_valid && out_ready;

  // One-hot decode of ld_row; indices >= K select nothing.
  always_comb begin
    w_row_sel = '0;
    for (int i = 0; i < K; i++) begin
      if (ld_row == RW'(i)) w_row_sel[i] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_ld_fire   = 1'b0;
    w_in_fire   = 1'b0;
    case (r_state)
      LOAD: begin
        w_ld_fire = ld_valid;
        if (ld_valid) w_mask_nxt = r_mask | w_row_sel;
        if (&w_mask_nxt) w_state_nxt = RUN;
      end
      RUN: begin
        w_in_fire = in_valid && in_ready;
      end
      default: ;
    endcase
    // clr discards any same-cycle load or input beat.
    if (clr) begin
      w_state_nxt = LOAD;
      w_mask_nxt  = '0;
      w_ld_fire   = 1'b0;
      w_in_fire   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
    end
  end

  // Basis storage is intentionally unreset; only the mask qualifies it.
  always_ff @(posedge clk) begin
    if (w_ld_fire) begin
      for (int i = 0; i < K; i++) begin
        if (w_row_sel[i]) r_h[i*M +: M] <= ld_data;
      end
    end
  end

  bmf_h_rowmux #(.K(K), .M(M), .XOR_MODE(XOR_MODE)) u_rowmux (
    .i_k  (in_k),
    .i_h  (r_h),
    .o_po (w_po)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_po    <= '0;
    end else if (clr) begin
      r_out_valid <= 1'b0;
      r_out_po    <= '0;
    end else if (w_in_fire) begin
      r_out_valid <= 1'b1;
      r_out_po    <= w_po;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef BMF_H_DECODER_ERR_MON_EN
  logic [M-1:0]     r_ref;
  logic [M-1:0]     w_diff;
  logic [CNT_W:0]   w_bits_sum;
  logic [CNT_W-1:0] r_err_bits, r_err_words, r_tot_words;

  assign w_diff     = r_out_po ^ r_ref;
  assign w_bits_sum = {1'b0, r_err_bits} + (CNT_W+1)'(popcount(64'(w_diff)));
  assign err_bits   = r_err_bits;
  assign err_words  = r_err_words;
  assign tot_words  = r_tot_words;

  // Saturating quality counters, stepped once per delivered word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref       <= '0;
      r_err_bits  <= '0;
      r_err_words <= '0;
      r_tot_words <= '0;
    end else if (clr) begin
      r_ref       <= '0;
      r_err_bits  <= '0;
      r_err_words <= '0;
      r_tot_words <= '0;
    end else begin
      if (w_in_fire) r_ref <= ref_po;
      if (w_out_fire) begin
        r_err_bits <= w_bits_sum[CNT_W] ? '1 : w_bits_sum[CNT_W-1:0];
        if (|w_diff && (r_err_words != '1)) r_err_words <= r_err_words + 1'b1;
        if (r_tot_words != '1) r_tot_words <= r_tot_words + 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/bmf_h_decoder.md
Name: bmf_h_decoder

Overview:
- Streaming, sequential decompressor for Boolean-matrix-factorised approximate blocks.
- Holds a K x M basis matrix H and reconstructs M primary outputs from each K-bit latent word: po = k (x) H.
- Product is the OR-of-ANDs semiring, or XOR-of-ANDs when XOR_MODE=1.
- Sits downstream of a compressor stage (pi -> k) in the approximate-circuit evaluation harness; H is loaded at run time, so one instance serves any partition and any k.

Parameters:
- K, 4, latent width (number of basis rows), 1..16
- M, 5, output width (number of basis columns), 1..64
- XOR_MODE, 0, 0 = OR accumulation (BMF semiring), 1 = XOR accumulation (GF(2))

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous return to LOAD; invalidates basis and pipeline
- ld_valid  in  1  basis row write request
- ld_ready  out  1  basis row write accepted when high with ld_valid
- ld_row  in  clog2(K) (min 1)  basis row index
- ld_data  in  M  basis row contents
- in_valid  in  1  latent word valid
- in_ready  out  1  latent word accepted when high with in_valid
- in_k  in  K  latent word, bit i selects row i
- out_valid  out  1  reconstructed word valid
- out_ready  in  1  downstream accepts
- out_po  out  M  reconstructed outputs
- basis_ok  out  1  all K rows written since last reset/clr

Behaviour:
- Reset (rst_n low, async) sets: state LOAD; row mask = 0; out_valid = 0; out_po = 0; basis_ok = 0; ld_ready = 1; in_ready = 0. Basis storage is not reset; it is don't-care until rewritten.
- States:
  - LOAD: ld_ready = 1, in_ready = 0.
    - Each ld_valid cycle writes H[ld_row] <= ld_data and sets mask[ld_row].
    - Rewriting a row overwrites it.
    - ld_row >= K is accepted and ignored: no write, no mask change.
    - When mask becomes all-ones, go to RUN on the next cycle; basis_ok = 1 from that cycle.
  - RUN: ld_ready = 0 (ld_valid ignored); in_ready = !out_valid || out_ready.
    - On accept: out_po <= XOR_MODE ? XOR_i(in_k[i] ? H[i] : 0) : OR_i(in_k[i] ? H[i] : 0); out_valid <= 1.
    - Latency is 1 cycle; full throughput when out_ready is held high.
    - out_valid and out_po hold stable while out_valid && !out_ready.
    - out_valid clears on out_ready when there is no new accept in the same cycle.
    - in_k = 0 produces out_po = 0.
- clr:
  - Any state: next cycle state = LOAD, mask = 0, basis_ok = 0, out_valid = 0, out_po = 0.
  - An in-flight output is dropped.
  - clr has priority over a same-cycle ld or in accept; that beat is discarded.
  - Basis contents are retained but are not valid until all rows are rewritten.
- Simultaneous events:
  - Output drain and new input accept in the same cycle: new word replaces old and out_valid stays 1.
  - Final row write and in_valid in the same cycle: input is not accepted (in_ready = 0 in LOAD).
- K = 1: ld_row is 1 bit; only row 0 is valid.
- rst_n deasserted mid-stream: everything returns to LOAD immediately, asynchronously.

Optional Feature:
- Macro: BMF_H_DECODER_ERR_MON_EN.
- When defined, added ports:
  - ref_po  in  M  exact output for in_k, sampled on in accept
  - err_bits  out  32  saturating sum of popcount(out_po ^ ref) per delivered word
  - err_words  out  32  saturating count of delivered words with any mismatch
  - tot_words  out  32  saturating count of delivered words
- Counters update on the out_valid && out_ready handshake. They reset on rst_n and clr and saturate at 32'hFFFFFFFF.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package bmf_pkg:
  - state enum (LOAD, RUN)
  - function clog2_min1
  - function popcount (parameterised via M)
  - constant CNT_W = 32
- Sub-module bmf_h_rowmux: purely combinational K x M select-and-accumulate, parameterised by XOR_MODE.
- FSM, handshake and counters stay in the top.

Test Plan:
- K=4, M=5, OR mode: load rows 5'b00001, 00010, 00100, 11000; send in_k=4'b1001 -> out_po=5'b11001, one cycle after accept; basis_ok=1.
- XOR_MODE=1, rows 5'b10101, 01111, all else 0: in_k=4'b0011 -> out_po=5'b11010; in_k=4'b0000 -> 5'b00000.
- Backpressure: out_ready=0 for 3 cycles with in_valid high -> in_ready=0, out_po held; on release, 4 back-to-back words delivered in order, no loss or duplicate.
- Load corner cases:
  - write row 2 twice with different data, then rows 0, 1, 3 -> second row-2 value is used.
  - ld_row=3 with K=3 -> ignored; basis_ok stays 0 until rows 0..2 are written.
- clr mid-stream with out_valid=1 and in_valid=1 -> next cycle out_valid=0, in_ready=0, ld_ready=1, basis_ok=0; rst_n pulse mid-cycle clears asynchronously.
- ERR_MON_EN: deliver 3 words with ref_po differing by 0, 2 and 5 bits -> err_bits=7, err_words=2, tot_words=3; preload near max -> saturates at 32'hFFFFFFFF.
